// File: rtl/word_scrambler.sv
// Letter-permutation engine: latches a target word, scrambles it with LFSR-driven
// swaps, applies player swaps and pulses isCorrect when the word is restored.
module word_scrambler #(
    parameter int unsigned ROUNDS = 8,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] wordIn,
    input  logic [2:0]  lettNum,
    input  logic        scramPls,
    input  logic        flipPls,
    input  logic [2:0]  indIn1,
    input  logic [2:0]  indIn2,
    input  logic        clrPls,
    output logic [29:0] wordOut,
    output logic        isCorrect,
    output logic        busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SCRAMBLE = 3'd1;
    localparam logic [2:0] READY    = 3'd2;
    localparam logic [2:0] CHECK    = 3'd3;
    localparam logic [2:0] SOLVED   = 3'd4;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    logic [2:0]  state;
    logic [29:0] work;
    logic [29:0] target;
    logic [2:0]  len;
    logic [3:0]  round;
    logic [7:0]  lfsr;

    logic [7:0]  lfsrNext;
    logic [2:0]  newLen;
    logic [29:0] loadWord;
    logic [2:0]  swapA;
    logic [2:0]  swapB;
    logic [29:0] scrambled;
    logic [29:0] flipped;
    logic        flipOk;

    // Mux-based letter swap keeps every slice index constant after unrolling.
    function automatic logic [29:0] swapLetters(input logic [29:0] w,
                                                input logic [2:0]  i,
                                                input logic [2:0]  j);
        logic [4:0]  li;
        logic [4:0]  lj;
        logic [29:0] r;
        li = '0;
        lj = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            if (3'(k) == i) li = w[k*5 +: 5];
            if (3'(k) == j) lj = w[k*5 +: 5];
        end
        r = w;
        for (int unsigned k = 0; k < 6; k++) begin
            if (3'(k) == i)      r[k*5 +: 5] = lj;
            else if (3'(k) == j) r[k*5 +: 5] = li;
        end
        return r;
    endfunction

    always_comb begin
        lfsrNext = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        newLen   = (lettNum >= 3'd4 && lettNum <= 3'd6) ? lettNum : 3'd4;
        loadWord = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            if (3'(k) < newLen) loadWord[k*5 +: 5] = wordIn[k*5 +: 5];
        end
        // len is 4..6, so one conditional subtract fully reduces a 3-bit value.
        swapA = lfsr[2:0];
        if (swapA >= len) swapA = swapA - len;
        swapB = lfsr[5:3];
        if (swapB >= len) swapB = swapB - len;
        scrambled = swapLetters(work, swapA, swapB);
        flipOk    = (indIn1 < len) && (indIn2 < len);
        flipped   = flipOk ? swapLetters(work, indIn1, indIn2) : work;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            work      <= '0;
            target    <= '0;
            len       <= 3'd4;
            round     <= '0;
            lfsr      <= SEED;
            isCorrect <= 1'b0;
        end else begin
            lfsr      <= lfsrNext;
            isCorrect <= 1'b0;
            if (clrPls) begin
                work   <= '0;
                target <= '0;
                state  <= IDLE;
            end else if (scramPls) begin
                len    <= newLen;
                target <= loadWord;
                work   <= loadWord;
                round  <= '0;
                state  <= SCRAMBLE;
            end else begin
                case (state)
                    SCRAMBLE: begin
                        work  <= scrambled;
                        round <= round + 4'd1;
                        if (round == LAST_ROUND) state <= READY;
                    end
                    READY: begin
                        if (flipPls) begin
                            work  <= flipped;
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (work == target) begin
                            isCorrect <= 1'b1;
                            state     <= SOLVED;
                        end else begin
                            state <= READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wordOut = work;
    assign busy    = (state == SCRAMBLE);

endmodule

// File: tb/tb_word_scrambler.sv
// Randomized self-checking bench for word_scrambler against an array-based model.
module tb_word_scrambler;

    localparam int         ROUNDS = 8;
    localparam logic [7:0] SEED   = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] wordIn;
    logic [2:0]  lettNum;
    logic        scramPls;
    logic        flipPls;
    logic [2:0]  indIn1;
    logic [2:0]  indIn2;
    logic        clrPls;
    logic [29:0] wordOut;
    logic        isCorrect;
    logic        busy;

    int nTests = 0;
    int nFail  = 0;
    int advCount = 0;

    logic [29:0] mCur;
    logic [29:0] mTgt;
    int          mLen;
    bit          mLocked;

    logic [29:0] game;

    word_scrambler #(.ROUNDS(ROUNDS), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .wordIn(wordIn), .lettNum(lettNum),
        .scramPls(scramPls), .flipPls(flipPls), .indIn1(indIn1), .indIn2(indIn2),
        .clrPls(clrPls), .wordOut(wordOut), .isCorrect(isCorrect), .busy(busy)
    );

    always #5 clk = ~clk;

    // Number of LFSR advances since the last reset edge.
    always @(posedge clk) advCount <= (!rst) ? 0 : advCount + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsrAt(input int n);
        logic [7:0] s;
        s = SEED;
        for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
    endfunction

    function automatic int letterOf(input logic [29:0] w, input int k);
        return int'(w[k*5 +: 5]);
    endfunction

    function automatic logic [29:0] maskWord(input logic [29:0] w, input int len);
        logic [29:0] r;
        r = '0;
        for (int k = 0; k < len; k++) r[k*5 +: 5] = w[k*5 +: 5];
        return r;
    endfunction

    function automatic logic [29:0] swapModel(input logic [29:0] w, input int i, input int j);
        int l[6];
        int t;
        logic [29:0] r;
        for (int k = 0; k < 6; k++) l[k] = letterOf(w, k);
        t = l[i]; l[i] = l[j]; l[j] = t;
        for (int k = 0; k < 6; k++) r[k*5 +: 5] = 5'(l[k]);
        return r;
    endfunction

    function automatic logic [29:0] scrModel(input logic [29:0] w, input int len, input int base);
        logic [29:0] r;
        logic [7:0]  s;
        r = w;
        for (int n = 1; n <= ROUNDS; n++) begin
            s = lfsrAt(base + n);
            r = swapModel(r, int'(s[2:0]) % len, int'(s[5:3]) % len);
        end
        return r;
    endfunction

    function automatic logic [29:0] randWord();
        logic [29:0] w;
        for (int k = 0; k < 6; k++) w[k*5 +: 5] = 5'($urandom_range(1, 26));
        return w;
    endfunction

    task automatic doScramble(input logic [29:0] w, input logic [2:0] ln, input string tag);
        int base;
        int cnt;
        wordIn   = w;
        lettNum  = ln;
        scramPls = 1'b1;
        base     = advCount;
        @(negedge clk);
        scramPls = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checkVal({tag, "_busy"}, cnt, ROUNDS);
        mLen    = (ln >= 3'd4 && ln <= 3'd6) ? int'(ln) : 4;
        mTgt    = maskWord(w, mLen);
        mCur    = scrModel(mTgt, mLen, base);
        mLocked = 1'b0;
        checkVal({tag, "_word"}, wordOut, mCur);
        checkVal({tag, "_noPulse"}, isCorrect, 1'b0);
    endtask

    task automatic doFlip(input int i, input int j, input string tag);
        bit expMatch;
        indIn1  = 3'(i);
        indIn2  = 3'(j);
        flipPls = 1'b1;
        @(negedge clk);
        flipPls  = 1'b0;
        expMatch = 1'b0;
        if (!mLocked) begin
            if (i < mLen && j < mLen) mCur = swapModel(mCur, i, j);
            expMatch = (mCur == mTgt);
            mLocked  = expMatch;
        end
        checkVal({tag, "_word"}, wordOut, mCur);
        checkVal({tag, "_early"}, isCorrect, 1'b0);
        @(negedge clk);
        checkVal({tag, "_pulse"}, isCorrect, expMatch);
    endtask

    task automatic solveWord(input string tag);
        int flips;
        int j;
        flips = 0;
        for (int i = 0; i < mLen && !mLocked; i++) begin
            if (letterOf(mCur, i) != letterOf(mTgt, i)) begin
                j = i + 1;
                while (j < mLen - 1 && letterOf(mCur, j) != letterOf(mTgt, i)) j++;
                doFlip(i, j, tag);
                flips++;
            end
        end
        if (flips == 0) doFlip(0, 0, tag);
        @(negedge clk);
        checkVal({tag, "_pulseOnce"}, isCorrect, 1'b0);
    endtask

    initial begin
        logic [29:0] held;
        logic [31:0] seen;
        bit          expMatch;

        rst = 1'b0; wordIn = '0; lettNum = 3'd4; scramPls = 1'b0;
        flipPls = 1'b0; indIn1 = '0; indIn2 = '0; clrPls = 1'b0;
        mCur = '0; mTgt = '0; mLen = 4; mLocked = 1'b1;
        game = {5'd0, 5'd0, 5'd5, 5'd13, 5'd1, 5'd7};

        repeat (2) @(negedge clk);
        checkVal("rst_word", wordOut, 30'd0);
        checkVal("rst_isCorrect", isCorrect, 1'b0);
        checkVal("rst_busy", busy, 1'b0);
        checkVal("rst_lfsr", dut.lfsr, SEED);
        rst = 1'b1;
        @(negedge clk);

        // GAME scramble: permutation of the four letters, upper positions blank.
        doScramble(game, 3'd4, "game");
        seen = '0;
        for (int k = 0; k < 4; k++) seen[letterOf(wordOut, k)] = 1'b1;
        checkVal("game_perm", seen, (32'd1 << 7) | (32'd1 << 1) | (32'd1 << 13) | (32'd1 << 5));
        checkVal("game_upper", wordOut[29:20], 10'd0);

        doScramble(game, 3'd4, "game2");
        solveWord("solve");
        doFlip(0, 1, "postSolve");

        doScramble(game, 3'd4, "bad");
        doFlip(5, 0, "badIdx");
        doFlip(1, 7, "badIdx2");

        doScramble(randWord(), 3'd7, "len7");
        checkVal("len7_upper", wordOut[29:20], 10'd0);

        // Restart while at round 3 of a scramble.
        wordIn = game; lettNum = 3'd4; scramPls = 1'b1;
        @(negedge clk);
        scramPls = 1'b0;
        checkVal("restart_busyStart", busy, 1'b1);
        repeat (3) @(negedge clk);
        doScramble(randWord(), 3'd5, "restart");

        // Clear beats scramble; flips in IDLE do nothing.
        wordIn = randWord(); lettNum = 3'd6; clrPls = 1'b1; scramPls = 1'b1;
        @(negedge clk);
        clrPls = 1'b0; scramPls = 1'b0;
        checkVal("clr_word", wordOut, 30'd0);
        checkVal("clr_busy", busy, 1'b0);
        mCur = '0; mTgt = '0; mLocked = 1'b1;
        doFlip(0, 1, "idleFlip");

        // Back-to-back flips: the second lands in CHECK and is dropped.
        doScramble(randWord(), 3'd6, "spacing");
        indIn1 = 3'd0; indIn2 = 3'd1; flipPls = 1'b1;
        @(negedge clk);
        indIn1 = 3'd2; indIn2 = 3'd3;
        @(negedge clk);
        flipPls  = 1'b0;
        mCur     = swapModel(mCur, 0, 1);
        expMatch = (mCur == mTgt);
        mLocked  = expMatch;
        checkVal("spacing_word", wordOut, mCur);
        checkVal("spacing_pulse", isCorrect, expMatch);
        @(negedge clk);

        for (int it = 0; it < 6; it++) begin
            doScramble(randWord(), 3'($urandom_range(0, 7)), "rand");
            for (int f = 0; f < 3; f++)
                doFlip(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "randFlip");
            if (!mLocked) solveWord("randSolve");
        end

        // Reset in the middle of a scramble.
        wordIn = game; lettNum = 3'd4; scramPls = 1'b1;
        @(negedge clk);
        scramPls = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkVal("rstMid_word", wordOut, 30'd0);
        checkVal("rstMid_busy", busy, 1'b0);
        checkVal("rstMid_lfsr", dut.lfsr, SEED);
        rst = 1'b1;
        @(negedge clk);

        // Reset during CHECK: no pulse escapes.
        doScramble(game, 3'd4, "rstChk");
        held = mCur;
        indIn1 = 3'd0; indIn2 = 3'd0; flipPls = 1'b1;
        @(negedge clk);
        flipPls = 1'b0;
        checkVal("rstChk_word", wordOut, held);
        rst = 1'b0;
        @(negedge clk);
        checkVal("rstChk_pulse", isCorrect, 1'b0);
        checkVal("rstChk_cleared", wordOut, 30'd0);
        rst = 1'b1;
        @(negedge clk);
        checkVal("rstChk_after", isCorrect, 1'b0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/word_scrambler.md
# word_scrambler

Letter-permutation engine directly downstream of the game controller. It latches the target word, scrambles it with a pseudo-random sequence of swaps when `scramPls` arrives, and applies player-requested letter swaps on each `flipPls`. After each player swap it compares the working word against the target and returns a one-cycle `isCorrect` pulse to the controller.

## Interface
- `ROUNDS`, 8: scramble swap rounds per `scramPls`; legal range 1..15.
- `SEED`, 8'hA5: LFSR value loaded at reset; must be nonzero.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `wordIn`  in  30  six 5-bit letters; `[4:0]` is position 0; 0 = blank, 1..26 = A..Z.
- `lettNum`  in  3  active word length, 4..6.
- `scramPls`  in  1  one-cycle request: load `wordIn` and scramble it.
- `flipPls`  in  1  one-cycle request: swap the letters at `indIn1` and `indIn2`.
- `indIn1`, `indIn2`  in  3 each  player swap positions.
- `clrPls`  in  1  abandon the current word and return to IDLE.
- `wordOut`  out  30  working (displayed) word.
- `isCorrect`  out  1  one-cycle pulse when a player swap solves the word.
- `busy`  out  1  high while scrambling.

## Operation
- States: IDLE, SCRAMBLE, READY, CHECK, SOLVED.
- Reset (`rst`=0 at an edge):
  - state=IDLE, work=0, target=0, len=4, round=0, lfsr=`SEED`.
  - `isCorrect`=0, `busy`=0.
- LFSR advances every cycle in every state except reset, Fibonacci form: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Priority in every state: reset > `clrPls` > `scramPls` > `flipPls`.
- `clrPls`: work=0, target=0, state=IDLE.
- `scramPls` (any state, including mid-scramble):
  - len <= `lettNum`; if `lettNum` is outside 4..6, len <= 4.
  - target and work load `wordIn`, with positions ≥ len forced to 0.
  - round <= 0; state=SCRAMBLE.
- SCRAMBLE, one swap per cycle:
  - a = lfsr[2:0], b = lfsr[5:3], each reduced mod len by a single conditional subtract (x ≥ len → x − len).
  - Swap work[a] and work[b]; if a==b the round still counts.
  - round increments; after round `ROUNDS`−1 completes, state=READY.
  - The scramble may leave work==target; no `isCorrect` is generated for that.
- READY, on `flipPls`:
  - If `indIn1`<len and `indIn2`<len: swap work[`indIn1`] and work[`indIn2`]; equal indices mean no change.
  - Otherwise work is unchanged.
  - State=CHECK in both cases.
- CHECK:
  - If work==target (all 30 bits): `isCorrect`=1 for this cycle only; state=SOLVED.
  - Else state=READY.
- SOLVED: work held; `flipPls` ignored; leaves only on `scramPls` or `clrPls`.
- `flipPls` is ignored in IDLE, SCRAMBLE, CHECK and SOLVED.
- `wordOut` = work register; `busy` = (state==SCRAMBLE).
- `isCorrect` is a registered output, high only during the CHECK cycle that matches.

## Timing
- `scramPls` sampled at edge T:
  - Load happens at edge T; `busy`=1 from edge T.
  - Swaps occur at edges T+1..T+`ROUNDS`.
  - State=READY and `busy`=0 after edge T+`ROUNDS`.
- `flipPls` sampled at edge F in READY:
  - `wordOut` shows the swap after edge F.
  - `isCorrect` is high between edge F+1 and edge F+2 on a match.
- Minimum spacing between accepted flips is 2 cycles; a `flipPls` landing in CHECK is dropped.
- `wordIn` and `lettNum` are sampled only on the `scramPls` edge.
- Reset mid-SCRAMBLE or mid-CHECK clears everything immediately; no pulse is emitted.

## Test plan
- **Reset:** hold `rst`=0 two cycles → `wordOut`=0, `isCorrect`=0, `busy`=0, LFSR=8'hA5.
- **Scramble:** `wordIn`="GAME" (7,1,13,5), `lettNum`=4, `scramPls` → `busy` high exactly 8 cycles.
  - Final `wordOut` is a permutation of {7,1,13,5}.
  - Bits [29:20] are 0.
  - Result matches the reference model driven from LFSR 8'hA5.
- **Solve:** scramble the same word; drive `flipPls` with the index pairs from the reference-model inverse.
  - `isCorrect` pulses exactly once, 2 cycles after the last flip.
  - Further flips are ignored (SOLVED).
- **Bad inputs:**
  - `lettNum`=4, `flipPls` with `indIn1`=5 → `wordOut` unchanged, no pulse.
  - `lettNum`=7 → len treated as 4.
- **Overlapping requests:**
  - `scramPls` at round 3 of a scramble → scramble restarts and `busy` lasts 8 more cycles.
  - `clrPls` asserted together with `scramPls` → IDLE, `wordOut`=0.
- **Flip spacing:** `flipPls` on two consecutive cycles → only the first swap is applied.
